adc_sar_result: RTL and testbench

Successive-approximation register and result buffer of the SAR ADC. It sits directly downstream of the SAR sequencing FSM, decodes its state word, and drives the capacitive DAC trial code from the comparator decision. Completed codes are pushed into a small first-word-fall-through buffer that the register bank or DMA drains through a valid/ready handshake.

---
 rtl/adc_sar_result_if.sv | 16 +
 rtl/adc_sar_result.sv | 133 +++++++++++++
 tb/tb_adc_sar_result.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_sar_result_if.sv
// Result-side port bundle of the SAR result buffer: head data with valid/ready,
// plus occupancy and the sticky overflow flag with its clear.
interface adc_sar_result_if #(
  parameter int N     = 8,
  parameter int DEPTH = 4
);
  logic [N-1:0]               data;
  logic                       valid;
  logic                       ready;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic                       ovf;
  logic                       ovf_clr;

  modport master (output data, valid, level, ovf, input ready, ovf_clr);
  modport slave  (input data, valid, level, ovf, output ready, ovf_clr);
endinterface

// File: rtl/adc_sar_result.sv
// SAR trial register driven by the sequencer state word, plus a FWFT result buffer.
// Define ADC_SAR_RESULT_FIFO_EN for a DEPTH-entry ring buffer; otherwise a single holding register.
module adc_sar_result #(
  parameter int N          = 8,
  parameter int STATE_SIZE = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [STATE_SIZE-1:0] current_state,
  input  logic                  comp,
  output logic [N-1:0]          dac_code,
  adc_sar_result_if.master      res
);

  localparam logic [STATE_SIZE-1:0] S_SAMPLE       = STATE_SIZE'(1);
  localparam logic [STATE_SIZE-1:0] S_EXTRA_SAMPLE = STATE_SIZE'(2);
  localparam logic [STATE_SIZE-1:0] S_CONVERT_0    = STATE_SIZE'(3);
  localparam logic [STATE_SIZE-1:0] S_CONVERT_LAST = STATE_SIZE'(3 + N - 1);
  localparam int LW = $clog2(DEPTH + 1);
`ifdef ADC_SAR_RESULT_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic [N-1:0]          dac_reg, dac_next;
  logic [STATE_SIZE-1:0] conv_idx;
  logic                  in_sample, in_convert, push;
  logic [N-1:0]          push_code;

  always_comb begin
    in_sample  = (current_state == S_SAMPLE) || (current_state == S_EXTRA_SAMPLE);
    in_convert = (current_state >= S_CONVERT_0) && (current_state <= S_CONVERT_LAST);
    conv_idx   = current_state - S_CONVERT_0;
    push       = enable && in_convert && (conv_idx == STATE_SIZE'(N - 1));
    push_code  = {dac_reg[N-1:1], comp};
    dac_next   = dac_reg;
    if (enable) begin
      if (in_sample) begin
        dac_next = {1'b1, {(N-1){1'b0}}};
      end else if (in_convert) begin
        // Resolve the bit under test and raise the next trial bit.
        for (int b = 0; b < N; b++) begin
          if (int'(conv_idx) == N - 1 - b)
            dac_next[b] = comp;
          else if (int'(conv_idx) == N - 2 - b)
            dac_next[b] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dac_reg <= '0;
    else     dac_reg <= dac_next;
  end

  logic [LW-1:0] count_reg, count_next;
  logic [N-1:0]  data_reg, data_next;
  logic          valid_reg, ovf_reg;
  logic          full, pop, push_ok, ovf_set;

  always_comb begin
    full       = (count_reg == LW'(CAP));
    pop        = valid_reg && res.ready;
    push_ok    = push && (!full || pop);
    ovf_set    = push && full && !pop;
    count_next = count_reg + LW'(push_ok) - LW'(pop);
  end

`ifdef ADC_SAR_RESULT_FIFO_EN
  localparam int AW = $clog2(DEPTH);
  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_code;
  end

  // The head is kept in data_reg so it is ready the cycle valid rises.
  always_comb begin
    rd_ptr_inc = rd_ptr_reg + AW'(1);
    data_next  = data_reg;
    if (count_reg == '0) begin
      if (push_ok) data_next = push_code;
    end else if (pop) begin
      if (count_reg == LW'(1)) begin
        if (push_ok) data_next = push_code;
      end else begin
        data_next = mem[rd_ptr_inc];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_inc;
    end
  end
`else
  always_comb begin
    data_next = push_ok ? push_code : data_reg;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      data_reg  <= data_next;
      valid_reg <= (count_next != '0);
      if (ovf_set)          ovf_reg <= 1'b1;
      else if (res.ovf_clr) ovf_reg <= 1'b0;
    end
  end

  assign dac_code  = dac_reg;
  assign res.data  = data_reg;
  assign res.valid = valid_reg;
  assign res.level = count_reg;
  assign res.ovf   = ovf_reg;

endmodule

// File: tb/tb_adc_sar_result.sv
// Directed bench for adc_sar_result: trial sequence, buffering, overflow, reset and enable freeze.
module tb_adc_sar_result;
  localparam int N          = 8;
  localparam int STATE_SIZE = 4;
  localparam int DEPTH      = 4;
`ifdef ADC_SAR_RESULT_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic                  comp;
  logic [STATE_SIZE-1:0] current_state;
  logic [N-1:0]          dac_code;

  adc_sar_result_if #(.N(N), .DEPTH(DEPTH)) res_if ();

  adc_sar_result #(.N(N), .STATE_SIZE(STATE_SIZE), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .current_state (current_state),
    .comp          (comp),
    .dac_code      (dac_code),
    .res           (res_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Trial code expected after CONVERT_k for a given final code (k=-1 means after SAMPLE).
  function automatic logic [7:0] exp_dac(input logic [7:0] code, input int k);
    logic [7:0] m;
    if (k < 0) return 8'h80;
    if (k == 7) return code;
    m = 8'hFF << (7 - k);
    return (code & m) | (8'h80 >> (k + 1));
  endfunction

  // rdy_mode: 0 ready low, 1 ready high, 2 ready only on last step, 3 ovf_clr on last step
  task automatic convert(input logic [7:0] code, input int rdy_mode, input int freeze_at);
    res_if.ready  = (rdy_mode == 1);
    current_state = 4'd1;
    comp          = 1'b0;
    tick;
    check("conv_sample_dac", 32'(dac_code), 32'(exp_dac(code, -1)));
    for (int k = 0; k < 8; k++) begin
      current_state = 4'(3 + k);
      if (k == freeze_at) begin
        enable = 1'b0;
        for (int f = 0; f < 5; f++) begin
          comp = ~comp;
          tick;
          check("freeze_dac", 32'(dac_code), 32'(exp_dac(code, k - 1)));
        end
        enable = 1'b1;
      end
      comp = code[7 - k];
      if (k == 7 && rdy_mode == 2) res_if.ready = 1'b1;
      if (k == 7 && rdy_mode == 3) res_if.ovf_clr = 1'b1;
      tick;
      check("conv_step_dac", 32'(dac_code), 32'(exp_dac(code, k)));
    end
    current_state  = 4'd0;
    res_if.ready   = 1'b0;
    res_if.ovf_clr = 1'b0;
    $display("conv code=0x%02h valid=%0d data=0x%02h level=%0d ovf=%0d",
             code, res_if.valid, res_if.data, res_if.level, res_if.ovf);
  endtask

  initial begin : stim
    logic [7:0] dac_tab [9];
    logic [7:0] fill [4];
    logic [7:0] pat;
    dac_tab = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5, 8'hA5};
    fill    = '{8'h11, 8'h22, 8'h33, 8'h44};
    pat     = 8'b1010_0101;

    rst = 1'b1; enable = 1'b1; comp = 1'b0; current_state = 4'd0;
    res_if.ready = 1'b0; res_if.ovf_clr = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    check("rst_dac",   32'(dac_code),      32'h0);
    check("rst_data",  32'(res_if.data),   32'h0);
    check("rst_valid", 32'(res_if.valid),  32'h0);
    check("rst_level", 32'(res_if.level),  32'h0);
    check("rst_ovf",   32'(res_if.ovf),    32'h0);

    // Reference conversion 0xA5 against the hand-computed trial table
    current_state = 4'd1;
    tick;
    check("t1_dac", 32'(dac_code), 32'(dac_tab[0]));
    for (int k = 0; k < 8; k++) begin
      current_state = 4'(3 + k);
      comp = pat[7 - k];
      tick;
      check("t1_dac", 32'(dac_code), 32'(dac_tab[k + 1]));
    end
    current_state = 4'd0;
    check("t1_valid", 32'(res_if.valid), 32'h1);
    check("t1_data",  32'(res_if.data),  32'hA5);
    check("t1_level", 32'(res_if.level), 32'h1);
    $display("conv code=0xa5 valid=%0d data=0x%02h level=%0d", res_if.valid, res_if.data, res_if.level);

    res_if.ready = 1'b1;
    tick;
    res_if.ready = 1'b0;
    check("pop_valid", 32'(res_if.valid), 32'h0);
    check("pop_level", 32'(res_if.level), 32'h0);
    check("pop_hold",  32'(res_if.data),  32'hA5);

    // Fill to capacity with no consumer
    for (int i = 0; i < CAP; i++) begin
      convert(fill[i], 0, -1);
      exp_q.push_back(fill[i]);
      check("fill_level", 32'(res_if.level), 32'(i + 1));
      check("fill_data",  32'(res_if.data),  32'(fill[0]));
      check("fill_ovf",   32'(res_if.ovf),   32'h0);
    end

    convert(8'h55, 0, -1);
    check("ovf_set",   32'(res_if.ovf),   32'h1);
    check("ovf_level", 32'(res_if.level), 32'(CAP));
    check("ovf_data",  32'(res_if.data),  32'(fill[0]));
    res_if.ovf_clr = 1'b1;
    tick;
    res_if.ovf_clr = 1'b0;
    check("ovf_clr", 32'(res_if.ovf), 32'h0);

    // Clear coincident with a fresh overflow: set wins
    convert(8'h66, 3, -1);
    check("ovf_setwins", 32'(res_if.ovf), 32'h1);
    res_if.ovf_clr = 1'b1;
    tick;
    res_if.ovf_clr = 1'b0;
    check("ovf_clr2", 32'(res_if.ovf), 32'h0);

    // Full buffer, push coincident with pop
    convert(8'h55, 2, -1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    check("both_level", 32'(res_if.level), 32'(CAP));
    check("both_ovf",   32'(res_if.ovf),   32'h0);
    check("both_data",  32'(res_if.data),  32'(exp_q[0]));

    res_if.ready = 1'b1;
    for (int g = 0; g < 16 && exp_q.size() > 0; g++) begin
      check("drain_valid", 32'(res_if.valid), 32'h1);
      check("drain_data",  32'(res_if.data),  32'(exp_q[0]));
      $display("pop data=0x%02h level=%0d", res_if.data, res_if.level);
      tick;
      void'(exp_q.pop_front());
    end
    res_if.ready = 1'b0;
    check("drain_level", 32'(res_if.level), 32'h0);
    check("drain_valid_end", 32'(res_if.valid), 32'h0);

    // Reset asserted while the FSM sits in CONVERT_3
    current_state = 4'd1;
    tick;
    for (int k = 0; k < 3; k++) begin
      current_state = 4'(3 + k);
      comp = k[0];
      tick;
    end
    current_state = 4'd6;
    comp = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rstmid_dac",   32'(dac_code),     32'h0);
    check("rstmid_valid", 32'(res_if.valid), 32'h0);
    check("rstmid_level", 32'(res_if.level), 32'h0);
    current_state = 4'd0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rstmid_nodata", 32'(res_if.data),  32'h0);
      check("rstmid_novld",  32'(res_if.valid), 32'h0);
    end
    $display("rst mid-conversion dac=0x%02h valid=%0d level=%0d", dac_code, res_if.valid, res_if.level);

    // Enable freeze during CONVERT_2 must not change the result
    convert(8'h5A, 0, 2);
    check("frz_valid", 32'(res_if.valid), 32'h1);
    check("frz_data",  32'(res_if.data),  32'h5A);
    res_if.ready = 1'b1;
    tick;
    res_if.ready = 1'b0;
    convert(8'h5A, 0, -1);
    check("ref_data",  32'(res_if.data),  32'h5A);
    check("ref_level", 32'(res_if.level), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
